// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its buffer.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int IMEM_AW     = 6;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} pairs.
// A flush empties the buffer and overrides any push or pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_entry,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [AW:0]    r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (i_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the head is only observed while the count is non-zero.
  always_ff @(posedge clk) begin
    if (reset && !i_flush && i_push) r_mem[r_wrPtr] <= i_entry;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: walks a fetch PC through the instruction ROM, buffers results,
// and hands them to decode over valid/ready, with redirect-flush and halt/drain.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [31:0]         imem_q,
  input  logic                redirect_valid,
  input  logic [63:0]         redirect_pc,
  input  logic                halt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [63:0]         out_pc,
  output logic                idle
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_stateNext;
  logic [63:0]   r_fetchPc;
  logic [63:0]   w_fetchPcNext;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_pushEntry;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;

  assign imem_addr   = r_fetchPc[IMEM_AW+1:2];
  assign w_valid     = (w_count != '0);
  // A redirect cancels the handshake, so the presented head is not consumed.
  assign w_pop       = w_valid & out_ready & ~redirect_valid;
  assign w_push      = (r_state == RUN) & ~halt & ~redirect_valid &
                       ((w_count < CW'(DEPTH)) | w_pop);
  assign w_pushEntry = '{pc: r_fetchPc, instr: imem_q};

  always_comb begin
    w_stateNext   = r_state;
    w_fetchPcNext = r_fetchPc;
    if (redirect_valid) begin
      w_fetchPcNext = redirect_pc & ~64'h3;
    end else begin
      if (w_push) w_fetchPcNext = r_fetchPc + 64'(INSTR_BYTES);
      case (r_state)
        RUN:     if (halt)  w_stateNext = HALT;
        HALT:    if (!halt) w_stateNext = RUN;
        default: w_stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= RUN;
      r_fetchPc <= RESET_PC;
    end else begin
      r_state   <= w_stateNext;
      r_fetchPc <= w_fetchPcNext;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_entry (w_pushEntry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign out_valid = w_valid;
  assign out_instr = w_valid ? w_head.instr : 32'h0;
  assign out_pc    = w_valid ? w_head.pc    : 64'h0;
  assign idle      = (r_state == HALT) && (w_count == '0);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios then random traffic, all compared
// against a queue-based model of the fetch stream.
module tb_imem_fetch_ctrl;

  localparam int          DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        idle;

  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .idle           (idle)
  );

  // Stub ROM: each word holds a tag plus its own word address.
  assign imem_q = 32'hA000_0000 | {26'b0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mQueue[$];
  logic [63:0] mPc;
  bit          mHalted;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] romWord(logic [63:0] pc);
    logic [63:0] wordIdx;
    wordIdx = (pc >> 2) % 64;
    return 32'hA000_0000 + wordIdx[31:0];
  endfunction

  task automatic checkValue(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    bit          expValid;
    logic [63:0] expPc;
    logic [31:0] expInstr;
    logic [63:0] addrWord;
    expValid = (mQueue.size() != 0);
    expPc    = expValid ? mQueue[0].pc    : 64'h0;
    expInstr = expValid ? mQueue[0].instr : 32'h0;
    addrWord = (mPc >> 2) % 64;
    checkValue("out_valid", {63'b0, out_valid}, {63'b0, expValid});
    checkValue("out_pc",    out_pc, expPc);
    checkValue("out_instr", {32'b0, out_instr}, {32'b0, expInstr});
    checkValue("idle",      {63'b0, idle}, {63'b0, (mHalted && mQueue.size() == 0)});
    checkValue("imem_addr", {58'b0, imem_addr}, addrWord);
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then check.
  task automatic applyStimulus(bit rv, logic [63:0] rpc, bit h, bit rdy, bit rst);
    bit popping;
    bit pushing;
    ent_t e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    out_ready      = rdy;
    reset          = rst;
    if (!rst) begin
      mPc = RESET_PC;
      mQueue.delete();
      mHalted = 1'b0;
    end else if (rv) begin
      mPc = rpc & ~64'h3;
      mQueue.delete();
    end else begin
      popping = (mQueue.size() > 0) && rdy;
      pushing = !mHalted && !h && ((mQueue.size() < DEPTH) || popping);
      if (popping) void'(mQueue.pop_front());
      if (pushing) begin
        e.pc    = mPc;
        e.instr = romWord(mPc);
        mQueue.push_back(e);
        mPc = mPc + 64'd4;
      end
      mHalted = h;
    end
    @(posedge clk);
    #2;
    checkOutput();
  endtask

  initial begin
    bit h;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    halt           = 1'b0;
    out_ready      = 1'b0;
    mPc            = RESET_PC;
    mHalted        = 1'b0;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);

    $display("[TB] sequential fetch after reset");
    applyStimulus(0, 0, 0, 1, 1);
    checkValue("t1_first_pc", out_pc, 64'h0);
    checkValue("t1_first_instr", {32'b0, out_instr}, 64'hA000_0000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
    checkValue("t1_pc12", out_pc, 64'd12);
    checkValue("t1_instr3", {32'b0, out_instr}, 64'hA000_0003);

    $display("[TB] backpressure");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);

    $display("[TB] redirect flush");
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 64'h43, 0, 1, 1);
    checkValue("t3_flush_valid", {63'b0, out_valid}, 64'h0);
    applyStimulus(0, 0, 0, 1, 1);
    checkValue("t3_target_pc", out_pc, 64'h40);
    checkValue("t3_target_instr", {32'b0, out_instr}, 64'hA000_0010);
    applyStimulus(0, 0, 0, 1, 1);

    $display("[TB] halt and drain");
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 1);
    checkValue("t4_idle", {63'b0, idle}, 64'h1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 1);

    $display("[TB] address wrap");
    applyStimulus(1, 64'hFC, 0, 1, 1);
    checkValue("t5_addr63", {58'b0, imem_addr}, 64'd63);
    applyStimulus(0, 0, 0, 1, 1);
    checkValue("t5_instr3f", {32'b0, out_instr}, 64'hA000_003F);
    applyStimulus(0, 0, 0, 1, 1);
    checkValue("t5_wrap_pc", out_pc, 64'h100);
    checkValue("t5_wrap_instr", {32'b0, out_instr}, 64'hA000_0000);

    $display("[TB] mid-stream reset");
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkValue("t6_valid", {63'b0, out_valid}, 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);

    $display("[TB] random traffic");
    h = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) h = ~h;
      applyStimulus(($urandom_range(0, 9) == 0), {$urandom, $urandom}, h,
                    $urandom_range(0, 1) == 1, ($urandom_range(0, 49) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
